// File: rtl/lane_wb_arbiter_pkg.sv
// rtl/lane_wb_arbiter_pkg.sv - shared write-back types, constants and bank select helper
package lane_wb_arbiter_pkg;

  localparam int unsigned NrWbSrc     = 3;
  localparam int unsigned NrVrfBanks  = 4;
  localparam int unsigned WbDataWidth = 64;
  localparam int unsigned WbAddrWidth = 10;
  localparam int unsigned WbIdWidth   = 3;

  // Write-back source indices; 2 and up are reserved for future VFUs
  typedef enum logic [1:0] {
    WB_VLU  = 2'd0,
    WB_VALU = 2'd1,
    WB_VFU2 = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [WbDataWidth-1:0]   data;
    logic [WbDataWidth/8-1:0] strb;
    logic [WbAddrWidth-1:0]   addr;
    logic [WbIdWidth-1:0]     id;
  } wb_req_t;

  // Banks are interleaved on the low address bits (nr_banks is a power of two)
  function automatic int unsigned vrf_bank_sel(input int unsigned addr,
                                               input int unsigned nr_banks);
    return addr & (nr_banks - 1);
  endfunction

endpackage

// File: rtl/lane_wb_arbiter_rr_arbiter.sv
// rtl/lane_wb_arbiter_rr_arbiter.sv - round-robin arbiter with its own rotating pointer
module rr_arbiter #(
  parameter  int unsigned NumReq = 3,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req,
  input  logic              en,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] ptr_q;
  logic            found;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Scan requests starting at the pointer; first hit wins
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

  assign gnt = (found && en) ? (NumReq'(1) << idx) : '0;

  // Advance the pointer past the winner only when a grant is actually issued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found && en) begin
      ptr_q <= (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/lane_wb_arbiter.sv
// rtl/lane_wb_arbiter.sv - N-source to M-bank VRF write-back arbiter; optional LANE_WB_ARB_PERF_CNT_EN counters
module lane_wb_arbiter
  import lane_wb_arbiter_pkg::*;
#(
  parameter  int unsigned NrSrc     = NrWbSrc,
  parameter  int unsigned NrBanks   = NrVrfBanks,
  parameter  int unsigned DataWidth = WbDataWidth,
  parameter  int unsigned AddrWidth = WbAddrWidth,
  parameter  int unsigned IdWidth   = WbIdWidth,
  localparam int unsigned BankW     = $clog2(NrBanks),
  localparam int unsigned RowW      = AddrWidth - BankW,
  localparam int unsigned SrcW      = (NrSrc > 1) ? $clog2(NrSrc) : 1,
  localparam int unsigned StrbW     = DataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrSrc-1:0]             wb_valid_i,
  output logic [NrSrc-1:0]             wb_gnt_o,
  input  logic [NrSrc*DataWidth-1:0]   wb_data_i,
  input  logic [NrSrc*StrbW-1:0]       wb_strb_i,
  input  logic [NrSrc*AddrWidth-1:0]   wb_addr_i,
  input  logic [NrSrc*IdWidth-1:0]     wb_id_i,
  input  logic [NrBanks-1:0]           bank_wready_i,
  output logic [NrBanks-1:0]           bank_we_o,
  output logic [NrBanks*RowW-1:0]      bank_waddr_o,
  output logic [NrBanks*DataWidth-1:0] bank_wdata_o,
  output logic [NrBanks*StrbW-1:0]     bank_wstrb_o,
  output logic [NrBanks-1:0]           wb_done_o,
  output logic [NrBanks*SrcW-1:0]      wb_done_src_o,
  output logic [NrBanks*IdWidth-1:0]   wb_done_id_o,
  output logic [NrBanks*32-1:0]        perf_conflict_o
);

  logic [NrBanks-1:0][NrSrc-1:0] req;
  logic [NrBanks-1:0][NrSrc-1:0] arb_gnt;
  logic [NrBanks-1:0]            free;
  logic [NrBanks-1:0]            retire;
  logic [BankW-1:0]              sel;

  // Route each valid source to the bank addressed by its low address bits
  always_comb begin
    req = '0;
    sel = '0;
    for (int unsigned s = 0; s < NrSrc; s++) begin
      sel = BankW'(vrf_bank_sel(32'(wb_addr_i[s*AddrWidth +: AddrWidth]), NrBanks));
      if (wb_valid_i[s]) req[sel][s] = 1'b1;
    end
  end

  // A source targets one bank only, so OR-ing the per-bank grants never double-grants
  always_comb begin
    wb_gnt_o = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      wb_gnt_o = wb_gnt_o | arb_gnt[b];
    end
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    logic [NrSrc-1:0]     gnt_b;
    logic [SrcW-1:0]      idx_b;
    logic [DataWidth-1:0] ld_data;
    logic [StrbW-1:0]     ld_strb;
    logic [RowW-1:0]      ld_row;
    logic [IdWidth-1:0]   ld_id;

    logic                 out_valid_q;
    logic [SrcW-1:0]      out_src_q;
    logic [IdWidth-1:0]   out_id_q;
    logic [RowW-1:0]      out_row_q;
    logic [DataWidth-1:0] out_data_q;
    logic [StrbW-1:0]     out_strb_q;

    // Reset also gates the grant so nothing is accepted while the bank is cleared
    assign free[b]   = (!out_valid_q || bank_wready_i[b]) && rst_ni;
    assign retire[b] = out_valid_q && (bank_wready_i[b] || (out_strb_q == '0));

    rr_arbiter #(
      .NumReq(NrSrc)
    ) u_rr_arbiter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req   (req[b]),
      .en    (free[b]),
      .gnt   (gnt_b),
      .idx   (idx_b)
    );

    assign arb_gnt[b] = gnt_b;

    // One-hot AND-OR mux of the granted source's payload
    always_comb begin
      ld_data = '0;
      ld_strb = '0;
      ld_row  = '0;
      ld_id   = '0;
      for (int unsigned s = 0; s < NrSrc; s++) begin
        if (gnt_b[s]) begin
          ld_data = ld_data | wb_data_i[s*DataWidth +: DataWidth];
          ld_strb = ld_strb | wb_strb_i[s*StrbW +: StrbW];
          ld_row  = ld_row  | wb_addr_i[s*AddrWidth+BankW +: RowW];
          ld_id   = ld_id   | wb_id_i[s*IdWidth +: IdWidth];
        end
      end
    end

    // Output register: a grant reloads (even while retiring), otherwise a retire empties it
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_valid_q <= 1'b0;
        out_src_q   <= '0;
        out_id_q    <= '0;
        out_row_q   <= '0;
        out_data_q  <= '0;
        out_strb_q  <= '0;
      end else if (|gnt_b) begin
        out_valid_q <= 1'b1;
        out_src_q   <= idx_b;
        out_id_q    <= ld_id;
        out_row_q   <= ld_row;
        out_data_q  <= ld_data;
        out_strb_q  <= ld_strb;
      end else if (retire[b]) begin
        out_valid_q <= 1'b0;
      end
    end

    assign bank_we_o[b]                          = out_valid_q && (out_strb_q != '0);
    assign bank_waddr_o[b*RowW +: RowW]          = out_row_q;
    assign bank_wdata_o[b*DataWidth +: DataWidth] = out_data_q;
    assign bank_wstrb_o[b*StrbW +: StrbW]        = out_strb_q;
    assign wb_done_o[b]                          = retire[b];
    assign wb_done_src_o[b*SrcW +: SrcW]         = out_src_q;
    assign wb_done_id_o[b*IdWidth +: IdWidth]    = out_id_q;

`ifdef LANE_WB_ARB_PERF_CNT_EN
    logic [31:0] perf_q;
    logic        multi_req;
    logic        conflict;

    assign multi_req = (req[b] & (req[b] - NrSrc'(1))) != '0;
    assign conflict  = (|req[b]) && (multi_req || !free[b]);

    // Saturating count of cycles where this bank could not serve every requester
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perf_q <= '0;
      end else if (conflict && (perf_q != 32'hFFFF_FFFF)) begin
        perf_q <= perf_q + 32'd1;
      end
    end

    assign perf_conflict_o[b*32 +: 32] = perf_q;
`else
    assign perf_conflict_o[b*32 +: 32] = 32'd0;
`endif
  end

endmodule

// File: tb/tb_lane_wb_arbiter.sv
// tb/tb_lane_wb_arbiter.sv - directed self-checking bench for lane_wb_arbiter
module tb_lane_wb_arbiter;

`ifdef LANE_WB_ARB_PERF_CNT_EN
  localparam int PerfOn = 1;
`else
  localparam int PerfOn = 0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [2:0]   wb_valid_i;
  logic [2:0]   wb_gnt_o;
  logic [191:0] wb_data_i;
  logic [23:0]  wb_strb_i;
  logic [29:0]  wb_addr_i;
  logic [8:0]   wb_id_i;
  logic [3:0]   bank_wready_i;
  logic [3:0]   bank_we_o;
  logic [31:0]  bank_waddr_o;
  logic [255:0] bank_wdata_o;
  logic [31:0]  bank_wstrb_o;
  logic [3:0]   wb_done_o;
  logic [7:0]   wb_done_src_o;
  logic [11:0]  wb_done_id_o;
  logic [127:0] perf_conflict_o;

  int n_cmp = 0;
  int n_err = 0;

  lane_wb_arbiter u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_valid_i     (wb_valid_i),
    .wb_gnt_o       (wb_gnt_o),
    .wb_data_i      (wb_data_i),
    .wb_strb_i      (wb_strb_i),
    .wb_addr_i      (wb_addr_i),
    .wb_id_i        (wb_id_i),
    .bank_wready_i  (bank_wready_i),
    .bank_we_o      (bank_we_o),
    .bank_waddr_o   (bank_waddr_o),
    .bank_wdata_o   (bank_wdata_o),
    .bank_wstrb_o   (bank_wstrb_o),
    .wb_done_o      (wb_done_o),
    .wb_done_src_o  (wb_done_src_o),
    .wb_done_id_o   (wb_done_id_o),
    .perf_conflict_o(perf_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [9:0] a,
                         input logic [2:0] id, input logic [63:0] d, input logic [7:0] st);
    wb_valid_i[s]         = v;
    wb_addr_i[s*10 +: 10] = a;
    wb_id_i[s*3 +: 3]     = id;
    wb_data_i[s*64 +: 64] = d;
    wb_strb_i[s*8 +: 8]   = st;
  endtask

  initial begin
    rst_ni        = 1'b0;
    wb_valid_i    = '0;
    wb_data_i     = '0;
    wb_strb_i     = '0;
    wb_addr_i     = '0;
    wb_id_i       = '0;
    bank_wready_i = 4'hF;
    tick();
    tick();
    check("rst_we", 64'(bank_we_o), 64'h0);
    check("rst_done", 64'(wb_done_o), 64'h0);
    check("rst_gnt", 64'(wb_gnt_o), 64'h0);
    check("rst_perf", 64'(|perf_conflict_o), 64'h0);
    rst_ni = 1'b1;
    tick();

    // Single VALU write to 0x005 -> bank 1, row 1
    set_src(1, 1'b1, 10'h005, 3'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    #1;
    check("t1_gnt", 64'(wb_gnt_o), 64'b010);
    tick();
    wb_valid_i = '0;
    #1;
    check("t1_we", 64'(bank_we_o), 64'b0010);
    check("t1_waddr", 64'(bank_waddr_o[8 +: 8]), 64'd1);
    check("t1_wdata", bank_wdata_o[64 +: 64], 64'hDEAD_BEEF_0123_4567);
    check("t1_done", 64'(wb_done_o), 64'b0010);
    check("t1_dsrc", 64'(wb_done_src_o[2 +: 2]), 64'd1);
    check("t1_did", 64'(wb_done_id_o[3 +: 3]), 64'd5);
    tick();
    check("t1_idle_we", 64'(bank_we_o), 64'h0);

    // Three sources hammer bank 2: rotation 0,1,2,0,1,2
    set_src(0, 1'b1, 10'h002, 3'd0, 64'h10, 8'h0F);
    set_src(1, 1'b1, 10'h006, 3'd1, 64'h11, 8'h0F);
    set_src(2, 1'b1, 10'h00A, 3'd2, 64'h12, 8'h0F);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t2_gnt%0d", k), 64'(wb_gnt_o), 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        check($sformatf("t2_done%0d", k), 64'(wb_done_o[2]), 64'd1);
        check($sformatf("t2_dsrc%0d", k), 64'(wb_done_src_o[4 +: 2]), 64'((k - 1) % 3));
      end
      tick();
    end
    wb_valid_i = '0;
    #1;
    check("t2_last_done", 64'(wb_done_o[2]), 64'd1);
    check("t2_last_src", 64'(wb_done_src_o[4 +: 2]), 64'd2);
    check("t2_perf2", 64'(perf_conflict_o[64 +: 32]), 64'(PerfOn * 6));
    tick();

    // Disjoint banks 0/1/3 all granted together
    set_src(0, 1'b1, 10'h004, 3'd6, 64'h20, 8'hFF);
    set_src(1, 1'b1, 10'h001, 3'd7, 64'h21, 8'hFF);
    set_src(2, 1'b1, 10'h003, 3'd3, 64'h22, 8'hFF);
    #1;
    check("t3_gnt", 64'(wb_gnt_o), 64'b111);
    tick();
    wb_valid_i = '0;
    #1;
    check("t3_done", 64'(wb_done_o), 64'b1011);
    check("t3_src_b0", 64'(wb_done_src_o[0 +: 2]), 64'd0);
    check("t3_src_b1", 64'(wb_done_src_o[2 +: 2]), 64'd1);
    check("t3_src_b3", 64'(wb_done_src_o[6 +: 2]), 64'd2);
    check("t3_waddr_b0", 64'(bank_waddr_o[0 +: 8]), 64'd1);
    tick();

    // Bank 0 stalled for three cycles while bank 1 keeps streaming
    bank_wready_i = 4'b1110;
    set_src(0, 1'b1, 10'h000, 3'd1, 64'hA0, 8'hFF);
    #1;
    check("t4_load_gnt", 64'(wb_gnt_o), 64'b001);
    tick();
    set_src(0, 1'b1, 10'h008, 3'd2, 64'hB0, 8'hFF);
    set_src(1, 1'b1, 10'h001, 3'd3, 64'hB1, 8'hFF);
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("t4_gnt%0d", j), 64'(wb_gnt_o), 64'b010);
      check($sformatf("t4_we0_%0d", j), 64'(bank_we_o[0]), 64'd1);
      check($sformatf("t4_waddr0_%0d", j), 64'(bank_waddr_o[0 +: 8]), 64'd0);
      check($sformatf("t4_done0_%0d", j), 64'(wb_done_o[0]), 64'd0);
      if (j > 0) check($sformatf("t4_done1_%0d", j), 64'(wb_done_o[1]), 64'd1);
      tick();
    end
    bank_wready_i = 4'hF;
    #1;
    check("t4_rel_done0", 64'(wb_done_o[0]), 64'd1);
    check("t4_rel_id0", 64'(wb_done_id_o[0 +: 3]), 64'd1);
    check("t4_rel_gnt", 64'(wb_gnt_o), 64'b011);
    tick();
    wb_valid_i = '0;
    #1;
    check("t4_b2b_we0", 64'(bank_we_o[0]), 64'd1);
    check("t4_b2b_waddr0", 64'(bank_waddr_o[0 +: 8]), 64'd2);
    check("t4_b2b_id0", 64'(wb_done_id_o[0 +: 3]), 64'd2);
    check("t4_perf0", 64'(perf_conflict_o[0 +: 32]), 64'(PerfOn * 3));
    tick();
    check("t4_idle_we", 64'(bank_we_o), 64'h0);

    // Zero-strobe write retires without we, despite wready low
    bank_wready_i = 4'b0111;
    set_src(2, 1'b1, 10'h003, 3'd4, 64'hC0, 8'h00);
    #1;
    check("t5_gnt", 64'(wb_gnt_o), 64'b100);
    tick();
    wb_valid_i = '0;
    #1;
    check("t5_we", 64'(bank_we_o), 64'h0);
    check("t5_done3", 64'(wb_done_o[3]), 64'd1);
    check("t5_src3", 64'(wb_done_src_o[6 +: 2]), 64'd2);
    check("t5_id3", 64'(wb_done_id_o[9 +: 3]), 64'd4);
    tick();
    check("t5_after_done", 64'(wb_done_o), 64'h0);

    // Two sources contend on bank 3 for ten cycles
    bank_wready_i = 4'hF;
    set_src(0, 1'b1, 10'h003, 3'd0, 64'hD0, 8'hFF);
    set_src(1, 1'b1, 10'h007, 3'd1, 64'hD1, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("t6_gnt%0d", k), 64'(wb_gnt_o), (k % 2 == 0) ? 64'b001 : 64'b010);
      tick();
    end
    wb_valid_i = '0;
    #1;
    check("t6_perf3", 64'(perf_conflict_o[96 +: 32]), 64'(PerfOn * 10));
    tick();

    // Reset during a stall drops the held entry without reporting done
    bank_wready_i = 4'b1110;
    set_src(0, 1'b1, 10'h000, 3'd5, 64'hE0, 8'hFF);
    #1;
    check("t7_gnt", 64'(wb_gnt_o), 64'b001);
    tick();
    #1;
    check("t7_held_we", 64'(bank_we_o[0]), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t7_rst_we", 64'(bank_we_o), 64'h0);
    check("t7_rst_done", 64'(wb_done_o), 64'h0);
    check("t7_rst_gnt", 64'(wb_gnt_o), 64'h0);
    check("t7_rst_perf", 64'(|perf_conflict_o), 64'h0);
    wb_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("t7_post_we", 64'(bank_we_o), 64'h0);
    check("t7_post_done", 64'(wb_done_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
